// File: rtl/ex_muldiv.sv
// Execute-stage multiply/divide unit with the HI/LO register pair.
// Multiplies take one cycle in MUL. Divides use a restoring divider that
// produces one quotient bit per cycle, MSB first. The unit holds the ID/EX
// register through exe_stall until HI/LO have been written.
module ex_muldiv #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [1:0]        hilo_we,
  input  logic              flush,
  output logic              exe_stall,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  // a_q holds a multiplicand, or the dividend that shifts into the quotient
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic [2*DATA_W-1:0] ext_a, ext_b, product;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic                op_signed;

  // Datapath helpers: product, trial subtraction, operand magnitudes
  always_comb begin
    ext_a     = {{DATA_W{~op_q[0] & a_q[DATA_W-1]}}, a_q};
    ext_b     = {{DATA_W{~op_q[0] & b_q[DATA_W-1]}}, b_q};
    product   = ext_a * ext_b;
    trial     = {rem_q, a_q[DATA_W-1]} - {1'b0, b_q};
    op_signed = ~op[0];
    abs_a     = (op_signed && src_a[DATA_W-1]) ? -src_a : src_a;
    abs_b     = (op_signed && src_b[DATA_W-1]) ? -src_b : src_b;
  end

  // Next-state logic; a flush overrides everything and suppresses HI/LO writes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          if (!op[1]) begin
            a_d     = src_a;
            b_d     = src_b;
            state_d = StMul;
          end else if (src_b == '0) begin
            // Divide by zero: all-ones quotient, raw dividend as remainder
            a_d     = '1;
            rem_d   = src_a;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = StFix;
          end else begin
            a_d     = abs_a;
            b_d     = abs_b;
            rem_d   = '0;
            q_neg_d = op_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            r_neg_d = op_signed & src_a[DATA_W-1];
            state_d = StDiv;
          end
        end else begin
          if (hilo_we[1]) hi_d = src_a;
          if (hilo_we[0]) lo_d = src_a;
        end
      end
      StMul: begin
        {hi_d, lo_d} = product;
        state_d      = StDone;
      end
      StDiv: begin
        if (!trial[DATA_W]) begin
          rem_d = trial[DATA_W-1:0];
          a_d   = {a_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[DATA_W-2:0], a_q[DATA_W-1]};
          a_d   = {a_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        lo_d    = q_neg_q ? -a_q : a_q;
        hi_d    = r_neg_q ? -rem_q : rem_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and register file update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall covers the accepting IDLE cycle and every busy state
  always_comb begin
    exe_stall = ((state_q == StIdle) && start && !flush) ||
                (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    done      = (state_q == StDone) && !flush;
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule
